ov7670_stream_gen: RTL and testbench
====================================

Name: ov7670_stream_gen

Overview:
Synthesisable OV7670 camera emulator that drives the same PCLK/VSYNC/HREF/D[7:0] byte stream the pixel-capture block receives, carrying RGB444 at two bytes per pixel. Used on the bench and on-board, muxed in place of the physical camera pins, to exercise capture, image buffer, pattern recognition and VGA paths with known, repeatable frames. Includes a zebra-stripe pattern for crossing-detection bring-up.

Parameters:
IMG_WIDTH, 640, active pixels per line
IMG_HEIGHT, 480, active lines per frame
H_BLANK, 288, byte slots per line with HREF low after the active bytes
VSYNC_LINES, 3, lines with VSYNC high at frame start
V_BACK_LINES, 17, blank lines after VSYNC, before the first active line
V_FRONT_LINES, 10, blank lines after the last active line
STRIPE_W, 32, zebra stripe width in pixels
SOLID_RGB, 12'hF00, colour for pattern 3

Ports:
clk  in  1  system clock; one byte slot = 2 clk cycles
rst_n  in  1  asynchronous active-low reset
enable  in  1  run frames; sampled at frame boundaries
pattern_sel  in  2  0 colour bars, 1 zebra, 2 ramp, 3 solid
pclk  out  1  emulated PCLK = clk/2
vsync  out  1  emulated VSYNC
href  out  1  emulated HREF
d  out  8  emulated data bus
frame_done  out  1  1-cycle pulse at end of each frame
frame_count  out  16  completed frames, wraps at 65535 -> 0
busy  out  1  high while not IDLE

Behaviour:
- Reset: pclk=0, vsync=0, href=0, d=0, frame_done=0, frame_count=0, busy=0, state IDLE.
- Reset is asynchronous and active-low: rst_n low mid-frame forces every output to its reset value immediately, with no frame_done pulse.
- pclk toggles every clk while busy and stays 0 in IDLE.
- vsync, href and d change only on the clk edge where pclk goes 1->0, hold for 2 clk cycles, and are stable at the pclk rising edge.
- LINE_SLOTS = 2*IMG_WIDTH + H_BLANK. Counters: slot (0..LINE_SLOTS-1), line, frame; widths via $clog2.
- FSM: IDLE -> VSYNC (VSYNC_LINES) -> VBACK (V_BACK_LINES) -> ACTIVE (IMG_HEIGHT lines) -> VFRONT (V_FRONT_LINES) -> IDLE or VSYNC.
  - IDLE -> VSYNC when enable=1. The first slot starts on the next clk; pclk first rises 1 clk later.
  - pattern_sel is latched on entry to VSYNC. Mid-frame changes are ignored.
- VSYNC: vsync=1, href=0, d=0 for all VSYNC_LINES*LINE_SLOTS slots.
- ACTIVE line: href=1 for slots 0..2*IMG_WIDTH-1, then href=0 and d=0 for H_BLANK slots.
  - Pixel x = slot>>1. Even slot d={4'h0,R}; odd slot d={G,B}.
- Patterns (x, y are active coordinates; f = frame_count[3:0]):
  - 0: 8 equal bars of width IMG_WIDTH/8: FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000.
  - 1: y < IMG_HEIGHT/2 -> 888. Otherwise (x/STRIPE_W) even -> FFF, odd -> 000.
  - 2: {x[3:0], y[3:0], f}.
  - 3: SOLID_RGB.
- Frame end: on the last clk of the last VFRONT slot, frame_done=1 for 1 clk and frame_count increments in the same cycle.
  - enable=1 -> VSYNC directly, with no gap slots. enable=0 -> IDLE, pclk stops at 0.
  - Deasserting enable mid-frame never truncates the frame.
- No backpressure: the stream is free-running, as with the real sensor.

Optional Feature:
OV7670_GEN_CHECKSUM_EN
- Defined: adds output frame_checksum[15:0].
  - Running sum mod 2^16 of all {R,G,B} 12-bit pixels, zero-extended, over the active region.
  - Updated from the previous frame's accumulator at the frame_done cycle; the accumulator clears on VSYNC entry; reset value 0.
  - Used to cross-check the capture and buffer path.
- Undefined: port and logic are absent; all other behaviour is identical.

Decomposition:
- Package ov7670_gen_pkg holds:
  - state_t enum {IDLE, VSYNC, VBACK, ACTIVE, VFRONT}
  - pattern_t enum
  - the 8 colour-bar RGB444 localparams
  - the BYTES_PER_PIXEL=2 constant
- Sub-module ov7670_pattern_gen: purely combinational (x, y, f, pattern, params) -> 12-bit RGB, reusable by the checker model.
- The top block owns the FSM, counters and byte serialisation.

Test Plan:
All tests use small params (IMG_WIDTH=8, IMG_HEIGHT=4, H_BLANK=4, VSYNC_LINES=1, V_BACK_LINES=1, V_FRONT_LINES=1): LINE_SLOTS=20, 7 lines, 140 slots = 280 clk.
- Frame timing: enable=1 from reset release, pattern 3 -> vsync high exactly 40 clk; 4 href pulses of 32 clk each, 40 clk apart; frame_done at clk 280 after first slot; frame_count=1.
- Byte format: pattern 3 with SOLID_RGB=12'hA5C -> bytes sampled on pclk rise alternate 8'h0A, 8'h5C; 16 bytes per line; d=0 while href=0.
- Zebra: STRIPE_W=2, pattern 1 -> lines 0-1 all pixels 888; lines 2-3 pixels FFF,FFF,000,000,FFF,FFF,000,000.
- Enable drop: deassert enable at line 3 of frame 0 -> frame completes; frame_count=1; busy=0; pclk held 0; no further href.
- Reset mid-frame: rst_n low during an ACTIVE slot -> all outputs 0 asynchronously (before the next clk edge); after release with enable=1, a clean frame restarts from VSYNC.
- Checksum (macro defined): pattern 2 for frame 0 -> frame_checksum equals the model sum of {x[3:0],y[3:0],4'h0} over 32 pixels; pattern_sel changed mid-frame has no effect until the next frame.

Source files
------------

// File: rtl/ov7670_gen_pkg.sv
// Shared types and constants for the OV7670 stream generator and its pattern source.
package ov7670_gen_pkg;

  localparam int unsigned BYTES_PER_PIXEL = 2;

  localparam logic [11:0] BAR_WHITE   = 12'hFFF;
  localparam logic [11:0] BAR_YELLOW  = 12'hFF0;
  localparam logic [11:0] BAR_CYAN    = 12'h0FF;
  localparam logic [11:0] BAR_GREEN   = 12'h0F0;
  localparam logic [11:0] BAR_MAGENTA = 12'hF0F;
  localparam logic [11:0] BAR_RED     = 12'hF00;
  localparam logic [11:0] BAR_BLUE    = 12'h00F;
  localparam logic [11:0] BAR_BLACK   = 12'h000;

  localparam logic [11:0] ZEBRA_GREY  = 12'h888;

  typedef enum logic [2:0] {
    IDLE,
    VSYNC,
    VBACK,
    ACTIVE,
    VFRONT
  } state_t;

  typedef enum logic [1:0] {
    PAT_BARS,
    PAT_ZEBRA,
    PAT_RAMP,
    PAT_SOLID
  } pattern_t;

  // Colour of bar idx, left to right.
  function automatic logic [11:0] bar_rgb(input logic [2:0] idx);
    logic [11:0] rgb;
    case (idx)
      3'd0:    rgb = BAR_WHITE;
      3'd1:    rgb = BAR_YELLOW;
      3'd2:    rgb = BAR_CYAN;
      3'd3:    rgb = BAR_GREEN;
      3'd4:    rgb = BAR_MAGENTA;
      3'd5:    rgb = BAR_RED;
      3'd6:    rgb = BAR_BLUE;
      default: rgb = BAR_BLACK;
    endcase
    return rgb;
  endfunction

endpackage

// File: rtl/ov7670_stream_gen_pattern.sv
// Combinational RGB444 test-pattern source: (x, y, frame nibble, pattern) -> pixel colour.
module ov7670_pattern_gen
  import ov7670_gen_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = 640,
  parameter int unsigned IMG_HEIGHT = 480,
  parameter int unsigned STRIPE_W   = 32,
  parameter logic [11:0] SOLID_RGB  = 12'hF00
) (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic [3:0]  f,
  input  pattern_t    pattern,
  output logic [11:0] rgb_c
);

  localparam int unsigned BAR_W    = (IMG_WIDTH >= 8) ? (IMG_WIDTH / 8) : 1;
  localparam int unsigned ZEBRA_Y0 = IMG_HEIGHT / 2;

  logic [31:0] bar_idx;
  logic        stripe_odd;

  assign bar_idx    = 32'(x) / BAR_W;
  assign stripe_odd = ((32'(x) / STRIPE_W) & 32'd1) != 32'd0;

  always_comb begin
    rgb_c = BAR_BLACK;
    case (pattern)
      PAT_BARS:  rgb_c = bar_rgb((bar_idx > 32'd7) ? 3'd7 : bar_idx[2:0]);
      PAT_ZEBRA: begin
        if (32'(y) < ZEBRA_Y0) rgb_c = ZEBRA_GREY;
        else                   rgb_c = stripe_odd ? BAR_BLACK : BAR_WHITE;
      end
      PAT_RAMP:  rgb_c = {x[3:0], y[3:0], f};
      default:   rgb_c = SOLID_RGB;
    endcase
  end

endmodule

// File: rtl/ov7670_stream_gen.sv
// OV7670 camera emulator: PCLK/VSYNC/HREF/D stream carrying RGB444, two bytes per pixel.
// Optional frame_checksum output is built when OV7670_GEN_CHECKSUM_EN is defined.
module ov7670_stream_gen
  import ov7670_gen_pkg::*;
#(
  parameter int unsigned IMG_WIDTH     = 640,
  parameter int unsigned IMG_HEIGHT    = 480,
  parameter int unsigned H_BLANK       = 288,
  parameter int unsigned VSYNC_LINES   = 3,
  parameter int unsigned V_BACK_LINES  = 17,
  parameter int unsigned V_FRONT_LINES = 10,
  parameter int unsigned STRIPE_W      = 32,
  parameter logic [11:0] SOLID_RGB     = 12'hF00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  output logic        pclk,
  output logic        vsync,
  output logic        href,
  output logic [7:0]  d,
  output logic        frame_done,
  output logic [15:0] frame_count,
  output logic        busy
`ifdef OV7670_GEN_CHECKSUM_EN
  ,
  output logic [15:0] frame_checksum
`endif
);

  localparam int unsigned ACTIVE_SLOTS = BYTES_PER_PIXEL * IMG_WIDTH;
  localparam int unsigned LINE_SLOTS   = ACTIVE_SLOTS + H_BLANK;
  localparam int unsigned MAX_V01      = (VSYNC_LINES > V_BACK_LINES) ? VSYNC_LINES : V_BACK_LINES;
  localparam int unsigned MAX_V23      = (IMG_HEIGHT > V_FRONT_LINES) ? IMG_HEIGHT : V_FRONT_LINES;
  localparam int unsigned MAX_LINES    = (MAX_V01 > MAX_V23) ? MAX_V01 : MAX_V23;
  localparam int unsigned SLOT_W       = $clog2(LINE_SLOTS);
  localparam int unsigned LINE_W       = $clog2(MAX_LINES + 1);

  state_t              state_q, state_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [LINE_W-1:0]   line_q, line_d;
  pattern_t            pat_q, pat_d;

  logic                pclk_d, vsync_d, href_d, frame_done_d, busy_d;
  logic [7:0]          d_d;
  logic [15:0]         frame_count_d;

  logic                launch;
  logic                slot_last, line_end, frame_last;
  logic [15:0]         pix_x, pix_y;
  logic [11:0]         pix_rgb;

  assign slot_last  = (slot_q == SLOT_W'(LINE_SLOTS - 1));
  assign frame_last = (state_q == VFRONT) && line_end && slot_last;

  // Last line of the region the FSM is currently in.
  always_comb begin
    line_end = 1'b0;
    case (state_q)
      VSYNC:   line_end = (line_q == LINE_W'(VSYNC_LINES - 1));
      VBACK:   line_end = (line_q == LINE_W'(V_BACK_LINES - 1));
      ACTIVE:  line_end = (line_q == LINE_W'(IMG_HEIGHT - 1));
      VFRONT:  line_end = (line_q == LINE_W'(V_FRONT_LINES - 1));
      default: line_end = 1'b0;
    endcase
  end

  // Next-state: a slot is two clocks; the position advances (launch) as pclk falls.
  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q;
    line_d        = line_q;
    pat_d         = pat_q;
    pclk_d        = 1'b0;
    frame_done_d  = 1'b0;
    frame_count_d = frame_count;
    launch        = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = VSYNC;
          slot_d  = '0;
          line_d  = '0;
          pat_d   = pattern_t'(pattern_sel);
          launch  = 1'b1;
        end
      end
      default: begin
        if (!pclk) begin
          pclk_d = 1'b1;
          if (frame_last) begin
            frame_done_d  = 1'b1;
            frame_count_d = frame_count + 16'd1;
          end
        end else begin
          launch = 1'b1;
          if (!slot_last) begin
            slot_d = slot_q + SLOT_W'(1);
          end else begin
            slot_d = '0;
            if (!line_end) begin
              line_d = line_q + LINE_W'(1);
            end else begin
              line_d = '0;
              case (state_q)
                VSYNC:  state_d = VBACK;
                VBACK:  state_d = ACTIVE;
                ACTIVE: state_d = VFRONT;
                default: begin
                  if (enable) begin
                    state_d = VSYNC;
                    pat_d   = pattern_t'(pattern_sel);
                  end else begin
                    state_d = IDLE;
                    launch  = 1'b0;
                  end
                end
              endcase
            end
          end
        end
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  assign pix_x = 16'(slot_d >> 1);
  assign pix_y = 16'(line_d);

  ov7670_pattern_gen #(
    .IMG_WIDTH  (IMG_WIDTH),
    .IMG_HEIGHT (IMG_HEIGHT),
    .STRIPE_W   (STRIPE_W),
    .SOLID_RGB  (SOLID_RGB)
  ) u_pattern (
    .x       (pix_x),
    .y       (pix_y),
    .f       (frame_count[3:0]),
    .pattern (pat_q),
    .rgb_c   (pix_rgb)
  );

  // Byte serialisation for the slot being launched; even slot carries R, odd carries G,B.
  always_comb begin
    vsync_d = vsync;
    href_d  = href;
    d_d     = d;
    if (launch) begin
      vsync_d = (state_d == VSYNC);
      href_d  = (state_d == ACTIVE) && (slot_d < SLOT_W'(ACTIVE_SLOTS));
      if (!href_d)        d_d = 8'h00;
      else if (slot_d[0]) d_d = pix_rgb[7:0];
      else                d_d = {4'h0, pix_rgb[11:8]};
    end else if (state_d == IDLE) begin
      vsync_d = 1'b0;
      href_d  = 1'b0;
      d_d     = 8'h00;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      slot_q      <= '0;
      line_q      <= '0;
      pat_q       <= PAT_BARS;
      pclk        <= 1'b0;
      vsync       <= 1'b0;
      href        <= 1'b0;
      d           <= 8'h00;
      frame_done  <= 1'b0;
      frame_count <= 16'd0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      line_q      <= line_d;
      pat_q       <= pat_d;
      pclk        <= pclk_d;
      vsync       <= vsync_d;
      href        <= href_d;
      d           <= d_d;
      frame_done  <= frame_done_d;
      frame_count <= frame_count_d;
      busy        <= busy_d;
    end
  end

`ifdef OV7670_GEN_CHECKSUM_EN
  logic [15:0] acc_q, acc_d, checksum_d;

  // Sum each pixel once, on its R-byte slot; publish at frame_done, clear on frame start.
  always_comb begin
    acc_d      = acc_q;
    checksum_d = frame_checksum;
    if (launch && (state_d == VSYNC) && (state_q != VSYNC)) acc_d = 16'd0;
    else if (launch && href_d && !slot_d[0])                acc_d = acc_q + 16'(pix_rgb);
    if (frame_done_d) checksum_d = acc_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q          <= 16'd0;
      frame_checksum <= 16'd0;
    end else begin
      acc_q          <= acc_d;
      frame_checksum <= checksum_d;
    end
  end
`endif

endmodule

// File: tb/tb_ov7670_stream_gen.sv
// Directed bench for ov7670_stream_gen with a byte scoreboard fed from an independent pixel model.
module tb_ov7670_stream_gen;

  localparam int unsigned W         = 8;
  localparam int unsigned H         = 4;
  localparam int unsigned HB        = 4;
  localparam int unsigned VS        = 1;
  localparam int unsigned VB        = 1;
  localparam int unsigned VF        = 1;
  localparam int unsigned SW        = 2;
  localparam logic [11:0] SOLID     = 12'hA5C;
  localparam int          LINE_CLK  = 2 * (2 * W + HB);
  localparam int          FRAME_CLK = LINE_CLK * (VS + VB + H + VF);
  localparam int          HREF_RISE = LINE_CLK * (VS + VB);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  pattern_sel = 2'd3;
  logic        pclk, vsync, href, frame_done, busy;
  logic [7:0]  d;
  logic [15:0] frame_count;
`ifdef OV7670_GEN_CHECKSUM_EN
  logic [15:0] frame_checksum;
`endif

  int          n_cmp = 0;
  int          n_bad = 0;
  int          frames = 0;
  logic [7:0]  sb[$];
  logic [15:0] csum_q[$];
  logic [7:0]  mon_exp;

  always #5 clk = ~clk;

  ov7670_stream_gen #(
    .IMG_WIDTH     (W),
    .IMG_HEIGHT    (H),
    .H_BLANK       (HB),
    .VSYNC_LINES   (VS),
    .V_BACK_LINES  (VB),
    .V_FRONT_LINES (VF),
    .STRIPE_W      (SW),
    .SOLID_RGB     (SOLID)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .pattern_sel (pattern_sel),
    .pclk        (pclk),
    .vsync       (vsync),
    .href        (href),
    .d           (d),
    .frame_done  (frame_done),
    .frame_count (frame_count),
    .busy        (busy)
`ifdef OV7670_GEN_CHECKSUM_EN
    ,
    .frame_checksum (frame_checksum)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] model_rgb(input int pat, input int x, input int y, input int f);
    logic [11:0] rgb;
    case (pat)
      0: case (x / (W / 8))
           0: rgb = 12'hFFF;  1: rgb = 12'hFF0;  2: rgb = 12'h0FF;  3: rgb = 12'h0F0;
           4: rgb = 12'hF0F;  5: rgb = 12'hF00;  6: rgb = 12'h00F;  default: rgb = 12'h000;
         endcase
      1: rgb = (y < int'(H / 2)) ? 12'h888 : (((x / SW) % 2 == 0) ? 12'hFFF : 12'h000);
      2: rgb = {4'(x), 4'(y), 4'(f)};
      default: rgb = SOLID;
    endcase
    return rgb;
  endfunction

  // Queue the expected active bytes and pixel sum of one frame.
  task automatic push_frame(input int pat, input int f);
    logic [11:0] rgb;
    logic [15:0] sum;
    sum = 16'd0;
    for (int y = 0; y < int'(H); y++) begin
      for (int x = 0; x < int'(W); x++) begin
        rgb = model_rgb(pat, x, y, f);
        sb.push_back({4'h0, rgb[11:8]});
        sb.push_back(rgb[7:0]);
        sum = sum + 16'(rgb);
      end
    end
    csum_q.push_back(sum);
  endtask

  // Byte monitor: one sample per slot, in the pclk-high half.
  always @(negedge clk) begin
    if (rst_n && pclk) begin
      if (href) begin
        check("byte_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          mon_exp = sb.pop_front();
          check("byte", 32'(d), 32'(mon_exp));
        end
      end else begin
        check("blank_d", 32'(d), 32'd0);
      end
    end
  end

  // Observe one frame from cycle 0 (caller is at that negedge); optionally change inputs mid-frame.
  task automatic run_frame(input int chg_cycle, input logic [1:0] new_pat, input logic new_en);
    int vs_cnt, vs_first, href_cnt, rises, first_rise, last_rise, fd_cnt, fd_cyc, pclk_bad;
    logic href_prev, en_after;
    logic [15:0] fc_obs, cs_obs, cs_exp;
    vs_cnt = 0; vs_first = -1; href_cnt = 0; rises = 0; first_rise = -1; last_rise = -1;
    fd_cnt = 0; fd_cyc = -1; pclk_bad = 0; href_prev = 1'b0; fc_obs = 16'd0; cs_obs = 16'd0;
    cs_exp = (csum_q.size() != 0) ? csum_q.pop_front() : 16'd0;
    check("frame_start_busy", 32'(busy), 32'd1);
    for (int c = 0; c < FRAME_CLK; c++) begin
      if (c == chg_cycle) begin
        pattern_sel = new_pat;
        enable      = new_en;
        if (new_en) push_frame(int'(new_pat), frames + 1);
      end
      if (pclk !== 1'(c % 2)) pclk_bad++;
      if (vsync) begin
        vs_cnt++;
        if (vs_first < 0) vs_first = c;
      end
      if (href) href_cnt++;
      if (href && !href_prev) begin
        rises++;
        if (first_rise < 0) first_rise = c;
        last_rise = c;
      end
      href_prev = href;
      if (frame_done) begin
        fd_cnt++;
        fd_cyc = c;
        fc_obs = frame_count;
`ifdef OV7670_GEN_CHECKSUM_EN
        cs_obs = frame_checksum;
`endif
      end
      @(negedge clk);
    end
    frames++;
    en_after = enable;
    check("pclk_toggle_errs", 32'(pclk_bad), 32'd0);
    check("vsync_clks", 32'(vs_cnt), 32'(LINE_CLK * VS));
    check("vsync_first", 32'(vs_first), 32'd0);
    check("href_pulses", 32'(rises), 32'(H));
    check("href_first_rise", 32'(first_rise), 32'(HREF_RISE));
    check("href_last_rise", 32'(last_rise), 32'(HREF_RISE + LINE_CLK * (H - 1)));
    check("href_clks", 32'(href_cnt), 32'(4 * W * H));
    check("frame_done_pulses", 32'(fd_cnt), 32'd1);
    check("frame_done_cycle", 32'(fd_cyc), 32'(FRAME_CLK - 1));
    check("frame_count", 32'(fc_obs), 32'(frames));
`ifdef OV7670_GEN_CHECKSUM_EN
    check("frame_checksum", 32'(cs_obs), 32'(cs_exp));
`else
    cs_obs = cs_exp;
`endif
    check("next_busy", 32'(busy), 32'(en_after));
    check("next_vsync", 32'(vsync), 32'(en_after));
    check("next_pclk", 32'(pclk), 32'd0);
    check("next_frame_done", 32'(frame_done), 32'd0);
  endtask

  task automatic idle_check(input int n);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      if (pclk !== 1'b0 || href !== 1'b0 || vsync !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) bad++;
      @(negedge clk);
    end
    check("idle_quiet", 32'(bad), 32'd0);
    check("idle_frame_count", 32'(frame_count), 32'(frames));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pclk"}, 32'(pclk), 32'd0);
    check({tag, "_vsync"}, 32'(vsync), 32'd0);
    check({tag, "_href"}, 32'(href), 32'd0);
    check({tag, "_d"}, 32'(d), 32'd0);
    check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    check({tag, "_frame_count"}, 32'(frame_count), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
`ifdef OV7670_GEN_CHECKSUM_EN
    check({tag, "_checksum"}, 32'(frame_checksum), 32'd0);
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    enable = 1'b0;
    pattern_sel = 2'd3;
    repeat (3) @(negedge clk);
    check_all_zero("reset");

    // Frame 0 solid, 1 zebra, 2 ramp; each selection made mid-frame takes effect only next frame.
    push_frame(3, 0);
    enable = 1'b1;
    rst_n  = 1'b1;
    @(negedge clk);
    run_frame(100, 2'd1, 1'b1);
    run_frame(100, 2'd2, 1'b1);
    run_frame(2 * LINE_CLK + LINE_CLK + 2, 2'd3, 1'b0);
    idle_check(60);

    // Restart, then pull reset during an active line.
    push_frame(3, frames);
    enable = 1'b1;
    @(negedge clk);
    repeat (HREF_RISE + 10) @(negedge clk);
    check("pre_reset_href", 32'(href), 32'd1);
    check("pre_reset_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    sb.delete();
    csum_q.delete();
    frames = 0;
    @(negedge clk);
    pattern_sel = 2'd0;
    push_frame(0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    run_frame(100, 2'd0, 1'b0);
    idle_check(40);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
